core_seq: RTL and testbench

- Upstream instruction sequencer for `core`. Generates the 51-bit `inst` word that runs one weight-stationary pass:
  - load the kernel from xmem into L0, then into the PE array;
  - stream activations through L0 and execute;
  - drain the ofifo into psum memory.
- Sits between the testbench/host (start, base addresses) and `core.inst`.

---
 rtl/core_seq_if.sv | 26 ++
 rtl/core_seq.sv | 192 +++++++++++++++++++
 tb/tb_core_seq.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/core_seq_if.sv
// Host/core-side signal bundle for the core_seq instruction sequencer.
// The sequencer uses the slave modport; the host/bench drives through master.
interface core_seq_if;
  logic        start;
  logic [10:0] w_base;
  logic [10:0] x_base;
  logic [10:0] p_base;
  logic        ofifo_valid;
  logic [50:0] inst;
  logic        busy;
  logic        done;
  logic [2:0]  state;

  // start is a one-cycle request honoured only when idle; ofifo_valid is a
  // level meaning "a row may be popped this cycle" and inst[6] pops it in the
  // same cycle, so one row moves per cycle where both are high.
  modport master (
    output start, w_base, x_base, p_base, ofifo_valid,
    input  inst, busy, done, state
  );

  modport slave (
    input  start, w_base, x_base, p_base, ofifo_valid,
    output inst, busy, done, state
  );
endinterface

// File: rtl/core_seq.sv
// Instruction sequencer for one weight-stationary pass of core: kernel load,
// activation streaming/execution, then ofifo drain into psum memory.
module core_seq #(
  parameter int row     = 4,
  parameter int col     = 8,
  parameter int len_nij = 36
) (
  input  logic       clk,
  input  logic       reset,
  core_seq_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    WRD  = 3'd1,
    KLD  = 3'd2,
    KWT  = 3'd3,
    XRD  = 3'd4,
    EXE  = 3'd5,
    DRN  = 3'd6,
    DN   = 3'd7
  } state_t;

  // All memory enables high (inactive), every strobe low.
  localparam logic [50:0] IDLE_WORD = 51'h6_0001_800C_0000;

  localparam logic [10:0] WRD_LAST = 11'(col);
  localparam logic [10:0] KLD_LAST = 11'(col - 1);
  localparam logic [10:0] KWT_LAST = 11'(row + col - 1);
  localparam logic [10:0] XRD_LAST = 11'(len_nij);
  localparam logic [10:0] EXE_LAST = 11'(len_nij - 1);
  localparam logic [10:0] DRN_LAST = 11'(len_nij - 1);
  localparam logic [10:0] W_READS  = 11'(col);
  localparam logic [10:0] X_READS  = 11'(len_nij);

  state_t      state;
  state_t      state_next;
  logic [10:0] cnt;
  logic [10:0] cnt_next;
  logic [10:0] w_base_q;
  logic [10:0] x_base_q;
  logic [10:0] p_base_q;
  logic        l0_wr_q;
  logic        xmem_rd;
  logic [10:0] xmem_addr;
  logic [50:0] inst_w;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      w_base_q <= '0;
      x_base_q <= '0;
      p_base_q <= '0;
      l0_wr_q  <= 1'b0;
    end else begin
      state   <= state_next;
      cnt     <= cnt_next;
      // SRAM read data arrives one cycle after the strobe, so L0 writes lag.
      l0_wr_q <= xmem_rd;
      if (state == IDLE && bus.start) begin
        w_base_q <= bus.w_base;
        x_base_q <= bus.x_base;
        p_base_q <= bus.p_base;
      end
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    case (state)
      IDLE: begin
        if (bus.start) begin
          state_next = WRD;
          cnt_next   = '0;
        end
      end
      WRD: begin
        if (cnt == WRD_LAST) begin
          state_next = KLD;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + 11'd1;
        end
      end
      KLD: begin
        if (cnt == KLD_LAST) begin
          state_next = KWT;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + 11'd1;
        end
      end
      KWT: begin
        if (cnt == KWT_LAST) begin
          state_next = XRD;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + 11'd1;
        end
      end
      XRD: begin
        if (cnt == XRD_LAST) begin
          state_next = EXE;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + 11'd1;
        end
      end
      EXE: begin
        if (cnt == EXE_LAST) begin
          state_next = DRN;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + 11'd1;
        end
      end
      DRN: begin
        // In DRN the counter counts completed pmem writes, not cycles.
        if (bus.ofifo_valid) begin
          if (cnt == DRN_LAST) begin
            state_next = DN;
            cnt_next   = '0;
          end else begin
            cnt_next = cnt + 11'd1;
          end
        end
      end
      DN: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  always_comb begin
    inst_w    = IDLE_WORD;
    xmem_rd   = 1'b0;
    xmem_addr = '0;
    case (state)
      WRD: begin
        if (cnt < W_READS) begin
          xmem_rd   = 1'b1;
          xmem_addr = w_base_q + cnt;
        end
      end
      KLD: begin
        inst_w[3] = 1'b1;
        inst_w[0] = 1'b1;
      end
      XRD: begin
        if (cnt < X_READS) begin
          xmem_rd   = 1'b1;
          xmem_addr = x_base_q + cnt;
        end
      end
      EXE: begin
        inst_w[3] = 1'b1;
        inst_w[1] = 1'b1;
      end
      DRN: begin
        // Mealy on ofifo_valid so a row is popped and written the same cycle.
        if (bus.ofifo_valid) begin
          inst_w[6]     = 1'b1;
          inst_w[32]    = 1'b0;
          inst_w[31]    = 1'b0;
          inst_w[30:20] = p_base_q + cnt;
        end
      end
      default: begin
        inst_w = IDLE_WORD;
      end
    endcase
    if (xmem_rd) begin
      inst_w[19]   = 1'b0;
      inst_w[18]   = 1'b1;
      inst_w[17:7] = xmem_addr;
    end
    inst_w[2] = l0_wr_q;
  end

  assign bus.inst  = inst_w;
  assign bus.busy  = (state != IDLE) && (state != DN);
  assign bus.done  = (state == DN);
  assign bus.state = state;

endmodule

// File: tb/tb_core_seq.sv
// Directed bench for core_seq: a schedule model fills an expected queue of
// {inst, busy, done} words that is popped and compared every cycle.
module tb_core_seq;

  localparam int ROW = 4;
  localparam int COL = 8;
  localparam int LEN = 36;
  localparam int PASS_LEN = (COL + 1) + COL + (ROW + COL) + (LEN + 1) + LEN + LEN + 1;
  localparam int TO_EXE   = (COL + 1) + COL + (ROW + COL) + (LEN + 1) + 5;
  localparam int TO_XRD   = (COL + 1) + COL + (ROW + COL) + 5;
  localparam logic [50:0] IDLE_WORD = 51'h6_0001_800C_0000;

  logic clk = 1'b0;
  logic reset = 1'b1;

  core_seq_if bus ();

  core_seq #(.row(ROW), .col(COL), .len_nij(LEN)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  logic [52:0] exp_q[$];
  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  int          start_cyc = 0;
  int          lat = 0;
  bit          m_busy = 1'b0;
  bit          m_drain = 1'b0;
  bit          prev_rd = 1'b0;
  bit          saw_done = 1'b0;
  logic [10:0] m_pb = '0;
  int          m_k = 0;
  int          n_l0wr = 0;
  int          n_kld = 0;
  int          n_exe = 0;
  int          n_pw = 0;
  int          n_done = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // l0_wr follows any xmem read strobe by exactly one cycle.
  task automatic push_word(input logic [50:0] w, input logic b, input logic d);
    logic [50:0] t;
    t = w;
    if (prev_rd) t[2] = 1'b1;
    prev_rd = ~t[19];
    exp_q.push_back({t, b, d});
  endtask

  task automatic gen_pass(input logic [10:0] wb, input logic [10:0] xb, input logic [10:0] pb);
    logic [50:0] w;
    for (int c = 0; c <= COL; c++) begin
      w = IDLE_WORD;
      if (c < COL) begin
        w[19]   = 1'b0;
        w[17:7] = wb + 11'(c);
      end
      push_word(w, 1'b1, 1'b0);
    end
    for (int c = 0; c < COL; c++) begin
      w = IDLE_WORD;
      w[3] = 1'b1;
      w[0] = 1'b1;
      push_word(w, 1'b1, 1'b0);
    end
    for (int c = 0; c < ROW + COL; c++) push_word(IDLE_WORD, 1'b1, 1'b0);
    for (int c = 0; c <= LEN; c++) begin
      w = IDLE_WORD;
      if (c < LEN) begin
        w[19]   = 1'b0;
        w[17:7] = xb + 11'(c);
      end
      push_word(w, 1'b1, 1'b0);
    end
    for (int c = 0; c < LEN; c++) begin
      w = IDLE_WORD;
      w[3] = 1'b1;
      w[1] = 1'b1;
      push_word(w, 1'b1, 1'b0);
    end
    m_pb    = pb;
    m_k     = 0;
    m_drain = 1'b1;
  endtask

  task automatic drain_word();
    logic [50:0] w;
    w = IDLE_WORD;
    if (bus.ofifo_valid) begin
      w[6]     = 1'b1;
      w[32]    = 1'b0;
      w[31]    = 1'b0;
      w[30:20] = m_pb + 11'(m_k);
      m_k++;
    end
    push_word(w, 1'b1, 1'b0);
    if (m_k == LEN) begin
      m_drain = 1'b0;
      push_word(IDLE_WORD, 1'b0, 1'b1);
    end
  endtask

  // One clock cycle: compare at the falling edge, advance to just past the rising edge.
  task automatic cycle();
    logic [52:0] exp_w;
    logic [52:0] obs_w;
    @(negedge clk);
    if (exp_q.size() == 0) begin
      if (m_drain) drain_word();
      else push_word(IDLE_WORD, 1'b0, 1'b0);
    end
    exp_w = exp_q.pop_front();
    obs_w = {bus.inst, bus.busy, bus.done};
    check($sformatf("cycle%0d_inst_busy_done", cyc), 64'(obs_w), 64'(exp_w));
    if (bus.inst[2]) n_l0wr++;
    if (bus.inst[0]) n_kld++;
    if (bus.inst[1]) n_exe++;
    if (!bus.inst[32]) n_pw++;
    if (bus.done) begin
      saw_done = 1'b1;
      n_done++;
      lat = cyc - start_cyc;
    end
    if (bus.start && !m_busy && !reset) begin
      gen_pass(bus.w_base, bus.x_base, bus.p_base);
      m_busy    = 1'b1;
      start_cyc = cyc;
      n_l0wr = 0;
      n_kld  = 0;
      n_exe  = 0;
      n_pw   = 0;
    end
    if (exp_w[0]) m_busy = 1'b0;
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input logic [10:0] wb, input logic [10:0] xb, input logic [10:0] pb);
    bus.w_base = wb;
    bus.x_base = xb;
    bus.p_base = pb;
    bus.start  = 1'b1;
    cycle();
    bus.start  = 1'b0;
    bus.w_base = 11'($urandom_range(0, 2047));
    bus.x_base = 11'($urandom_range(0, 2047));
    bus.p_base = 11'($urandom_range(0, 2047));
  endtask

  task automatic run_pass(input bit tog, input bit chk_lat, input int exp_lat);
    saw_done = 1'b0;
    for (int i = 0; i < 400 && !saw_done; i++) begin
      if (tog) bus.ofifo_valid = ~bus.ofifo_valid;
      cycle();
    end
    check("done_seen", 64'(saw_done), 64'(1));
    if (chk_lat) check("done_latency", 64'(lat), 64'(exp_lat));
    check("l0_wr_count", 64'(n_l0wr), 64'(COL + LEN));
    check("kld_count", 64'(n_kld), 64'(COL));
    check("exe_count", 64'(n_exe), 64'(LEN));
    check("pmem_write_count", 64'(n_pw), 64'(LEN));
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    exp_q.delete();
    m_busy  = 1'b0;
    m_drain = 1'b0;
    prev_rd = 1'b0;
    cycle();
    reset = 1'b0;
  endtask

  initial begin
    bus.start       = 1'b0;
    bus.w_base      = '0;
    bus.x_base      = '0;
    bus.p_base      = '0;
    bus.ofifo_valid = 1'b0;
    @(posedge clk);
    #1;
    cycle();
    cycle();
    reset = 1'b0;
    repeat (5) cycle();
    check("idle_inst", 64'(bus.inst), 64'(IDLE_WORD));
    check("idle_busy", 64'(bus.busy), 64'(0));
    check("idle_done", 64'(bus.done), 64'(0));

    // Pass A: no drain stalls.
    bus.ofifo_valid = 1'b1;
    pulse_start(11'd0, 11'd100, 11'd0);
    run_pass(1'b0, 1'b1, PASS_LEN);
    repeat (3) cycle();

    // Pass B: ofifo_valid alternating every cycle.
    pulse_start(11'd10, 11'd200, 11'd500);
    run_pass(1'b1, 1'b0, 0);
    bus.ofifo_valid = 1'b1;
    repeat (3) cycle();

    // Pass C: kernel and psum addresses wrap; a start during EXE is ignored.
    pulse_start(11'd2045, 11'd1000, 11'd2040);
    repeat (TO_EXE) cycle();
    pulse_start(11'd7, 11'd7, 11'd7);
    run_pass(1'b0, 1'b1, PASS_LEN);
    repeat (3) cycle();

    // Pass D: reset in the middle of XRD aborts with no done pulse.
    pulse_start(11'd300, 11'd400, 11'd600);
    repeat (TO_XRD) cycle();
    check("xrd_busy_before_reset", 64'(bus.busy), 64'(1));
    n_done = 0;
    apply_reset();
    check("abort_inst", 64'(bus.inst), 64'(IDLE_WORD));
    repeat (150) cycle();
    check("abort_no_done", 64'(n_done), 64'(0));
    check("abort_busy", 64'(bus.busy), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
